pll_lock_sequencer: RTL and testbench

- Sequences the core's clock-generation PLL through power-up, lock acquisition and recovery. It runs on the PLL reference clock.
- Drives the PLL reset, monitors the PLL lock output, and holds the core in reset until lock has been stable for a programmed time.
- On lock loss or timeout, re-resets the PLL with bounded retries. After the retries are exhausted it latches a fault for the OSD/HPS status bits.

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
package pll_seq_pkg;

    localparam int unsigned RETRY_W = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_MAX = (1 << RETRY_W) - 1;

    typedef enum logic [STATE_W-1:0] {
        RESET_PLL   = 3'd0,
        WAIT_LOCK   = 3'd1,
        STABLE_WAIT = 3'd2,
        RUN         = 3'd3,
        FAULT       = 3'd4
    } pll_state_e;

    // Largest of the three terminal counts; sizes the shared timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-high clear.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the core PLL through reset, lock acquisition and stability qualification,
// retrying on lock loss or timeout and latching a fault once retries are exhausted.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               req_reset,
    output logic               pll_rst,
    output logic               sys_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned TIMER_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_SAT   = RETRY_W'(RETRY_MAX);

    pll_state_e         cur_state;
    pll_state_e         next_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_d;
    logic [RETRY_W-1:0] retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               locked_s;
    logic               fail;
    logic               timer_run;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state, retry and timer decode.
    always_comb begin
        next_state = cur_state;
        retry_d    = retry_cnt;
        fail       = 1'b0;
        timer_run  = 1'b0;
        retry_inc  = (retry_cnt == RETRY_SAT) ? RETRY_SAT : retry_cnt + RETRY_W'(1);

        case (cur_state)
            RESET_PLL: begin
                timer_run = 1'b1;
                if (timer == RST_LAST) begin
                    next_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                timer_run = 1'b1;
                // A lock arriving on the timeout cycle still counts as lock.
                if (locked_s) begin
                    next_state = STABLE_WAIT;
                end else if (timer == LOCK_LAST) begin
                    fail = 1'b1;
                end
            end
            STABLE_WAIT: begin
                timer_run = 1'b1;
                // A drop on the final qualification cycle still counts as a failure.
                if (!locked_s) begin
                    fail = 1'b1;
                end else if (timer == STABLE_LAST) begin
                    next_state = RUN;
                    retry_d    = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    fail = 1'b1;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = RESET_PLL;
            end
        endcase

        if (fail) begin
            retry_d    = retry_inc;
            next_state = (retry_inc >= RETRY_LIMIT) ? FAULT : RESET_PLL;
        end

        if (req_reset) begin
            next_state = RESET_PLL;
            retry_d    = '0;
        end

        // Timer only runs in the timed states and restarts on every state entry.
        if (req_reset || (next_state != cur_state) || !timer_run) begin
            timer_d = '0;
        end else begin
            timer_d = timer + TIMER_W'(1);
        end
    end

    // State, counters and Moore outputs decoded from the next state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur_state <= RESET_PLL;
            timer     <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            cur_state <= next_state;
            timer     <= timer_d;
            retry_cnt <= retry_d;
            pll_rst   <= (next_state == RESET_PLL) || (next_state == FAULT);
            sys_reset <= (next_state != RUN);
            ready     <= (next_state == RUN);
            fault     <= (next_state == FAULT);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed, table-driven bench for pll_lock_sequencer with small parameters.
module tb_pll_lock_sequencer;

    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    typedef struct {
        int unsigned cycles;
        logic        locked;
        logic        req;
        logic [2:0]  st;
        logic        prst;
        logic        srst;
        logic        rdy;
        logic        flt;
        logic [3:0]  retry;
    } vec_t;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .req_reset  (req_reset),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 refclk = ~refclk;

    function automatic logic [10:0] observed();
        return {state, pll_rst, sys_reset, ready, fault, retry_cnt};
    endfunction

    function automatic logic [10:0] expect_out(input logic [2:0] st, input logic pr,
                                               input logic sr, input logic rd,
                                               input logic fl, input logic [3:0] rt);
        return {st, pr, sr, rd, fl, rt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic add(input int unsigned c, input logic lk, input logic rq,
                       input logic [2:0] st, input logic pr, input logic sr,
                       input logic rd, input logic fl, input logic [3:0] rt);
        tbl.push_back('{c, lk, rq, st, pr, sr, rd, fl, rt});
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            pll_locked = tbl[i].locked;
            req_reset  = tbl[i].req;
            tick(tbl[i].cycles);
            check($sformatf("row%0d", i), 32'(observed()),
                  32'(expect_out(tbl[i].st, tbl[i].prst, tbl[i].srst,
                                 tbl[i].rdy, tbl[i].flt, tbl[i].retry)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, required < 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic saw_ready;

        // Power-up, then lock loss in RUN with recovery (rows 0..14).
        add(3, 0, 0, S_RST,  1, 1, 0, 0, 0);
        add(1, 0, 0, S_WAIT, 0, 1, 0, 0, 0);
        add(6, 0, 0, S_WAIT, 0, 1, 0, 0, 0);
        add(2, 1, 0, S_WAIT, 0, 1, 0, 0, 0);
        add(1, 1, 0, S_STAB, 0, 1, 0, 0, 0);
        add(7, 1, 0, S_STAB, 0, 1, 0, 0, 0);
        add(1, 1, 0, S_RUN,  0, 0, 1, 0, 0);
        add(1, 0, 0, S_RUN,  0, 0, 1, 0, 0);
        add(1, 1, 0, S_RUN,  0, 0, 1, 0, 0);
        add(1, 1, 0, S_RST,  1, 1, 0, 0, 1);
        add(3, 1, 0, S_RST,  1, 1, 0, 0, 1);
        add(1, 1, 0, S_WAIT, 0, 1, 0, 0, 1);
        add(1, 1, 0, S_STAB, 0, 1, 0, 0, 1);
        add(7, 1, 0, S_STAB, 0, 1, 0, 0, 1);
        add(1, 1, 0, S_RUN,  0, 0, 1, 0, 0);
        // Timeouts into FAULT, then req_reset out of FAULT (rows 15..27).
        add(1,  0, 1, S_RST,   1, 1, 0, 0, 0);
        add(3,  0, 0, S_RST,   1, 1, 0, 0, 0);
        add(1,  0, 0, S_WAIT,  0, 1, 0, 0, 0);
        add(19, 0, 0, S_WAIT,  0, 1, 0, 0, 0);
        add(1,  0, 0, S_RST,   1, 1, 0, 0, 1);
        add(3,  0, 0, S_RST,   1, 1, 0, 0, 1);
        add(1,  0, 0, S_WAIT,  0, 1, 0, 0, 1);
        add(19, 0, 0, S_WAIT,  0, 1, 0, 0, 1);
        add(1,  0, 0, S_FAULT, 1, 1, 0, 1, 2);
        add(30, 0, 0, S_FAULT, 1, 1, 0, 1, 2);
        add(1,  0, 1, S_RST,   1, 1, 0, 0, 0);
        add(4,  0, 0, S_WAIT,  0, 1, 0, 0, 0);
        add(5,  0, 0, S_WAIT,  0, 1, 0, 0, 0);

        rst        = 1'b1;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        tick(2);
        check("reset_values", 32'(observed()), 32'(expect_out(S_RST, 1, 1, 0, 0, 0)));
        rst = 1'b0;

        run_rows(0, 14);

        // req_reset held 10 cycles in RUN: pll_rst covers the hold plus a full reset pulse.
        req_reset = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            n++;
            if (n == 10) req_reset = 1'b0;
            if (!pll_rst) break;
        end
        check("req_hold_prst_len", 32'(n), 32'd14);
        check("req_hold_after", 32'(observed()), 32'(expect_out(S_WAIT, 0, 1, 0, 0, 0)));

        // One-cycle glitch seen by the synchronised lock at stable count 5.
        tick(1);
        check("stab_enter", 32'(state), 32'(S_STAB));
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        n = 0;
        saw_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            n++;
            if (ready) saw_ready = 1'b1;
            if (state != S_STAB) break;
        end
        check("glitch_cycles", 32'(n), 32'd2);
        check("glitch_ready", 32'(saw_ready), 32'd0);
        check("glitch_after", 32'(observed()), 32'(expect_out(S_RST, 1, 1, 0, 0, 1)));

        run_rows(15, 27);

        // Asynchronous rst between edges while in WAIT_LOCK.
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(observed()), 32'(expect_out(S_RST, 1, 1, 0, 0, 0)));
        tick(2);
        rst = 1'b0;
        tick(3);
        check("post_rst_hold", 32'(observed()), 32'(expect_out(S_RST, 1, 1, 0, 0, 0)));
        tick(1);
        check("post_rst_release", 32'(observed()), 32'(expect_out(S_WAIT, 0, 1, 0, 0, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
